// File: rtl/lsu_if.sv
// Request/response and data-memory signals of the load/store unit.
// The slave modport is the LSU view; the master modport is the CPU/memory side.
interface lsu_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_store;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;
  logic [1:0]      mem_we;
  logic [XLEN-1:0] mem_a;
  logic [XLEN-1:0] mem_wd;
  logic [XLEN-1:0] mem_rd;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rd,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_a, mem_wd
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rd,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/lsu_align.sv
// Load/store alignment unit in front of the data memory.
// Loads: lane extraction and extension, two word reads when crossing a word.
// Stores: aligned SB/SH/SW go straight through, misaligned ones become byte stores.
module lsu_align #(
  parameter int XLEN = 32
) (
  input logic  clk,
  input logic  rst_n,
  lsu_if.slave bus
);

  typedef enum logic {IDLE, ACC} state_t;

  state_t          state_q, state_d;
  logic            store_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] addr_q, wdata_q, lo_q;
  logic [1:0]      k_q;

  logic [1:0]      off;
  logic [2:0]      size;
  logic            illegal, misaligned, crossing;
  logic            done, lo_capture;
  logic [1:0]      we;
  logic [XLEN-1:0] addr_out, wd_out;
  logic [7:0]      wbyte;
  logic [63:0]     window;
  logic [XLEN-1:0] ldata, lext;
  logic            rsp_valid_q, rsp_err_q;
  logic [XLEN-1:0] rsp_rdata_q;

  assign off   = addr_q[1:0];
  assign wbyte = 8'(wdata_q >> {k_q, 3'b000});

  // Access size and legality of the latched request
  always_comb begin
    size = 3'd4;
    case (f3_q[1:0])
      2'b00:   size = 3'd1;
      2'b01:   size = 3'd2;
      default: size = 3'd4;
    endcase
    illegal    = store_q ? (f3_q > 3'b010) : ((f3_q == 3'b011) || (f3_q[2:1] == 2'b11));
    misaligned = ((size == 3'd2) && off[0]) || ((size == 3'd4) && (off != 2'b00));
    crossing   = ({1'b0, off} + size) > 3'd4;
  end

  // Load result: shift the one- or two-word window down and extend
  always_comb begin
    window = crossing ? {bus.mem_rd, lo_q} : {32'b0, bus.mem_rd};
    ldata  = 32'(window >> {off, 3'b000});
    case (f3_q)
      3'b000:  lext = {{24{ldata[7]}}, ldata[7:0]};
      3'b001:  lext = {{16{ldata[15]}}, ldata[15:0]};
      3'b100:  lext = {24'b0, ldata[7:0]};
      3'b101:  lext = {16'b0, ldata[15:0]};
      default: lext = ldata;
    endcase
  end

  // Next state and per-access memory drive; memory outputs are idle outside ACC
  always_comb begin
    state_d    = state_q;
    we         = 2'b00;
    addr_out   = '0;
    wd_out     = '0;
    done       = 1'b0;
    lo_capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) state_d = ACC;
      end
      ACC: begin
        if (illegal) begin
          done = 1'b1;
        end else if (store_q) begin
          if (!misaligned) begin
            we       = (size == 3'd4) ? 2'b01 : ((size == 3'd2) ? 2'b10 : 2'b11);
            addr_out = addr_q;
            wd_out   = wdata_q;
            done     = 1'b1;
          end else begin
            we       = 2'b11;
            addr_out = addr_q + XLEN'(k_q);
            wd_out   = {24'b0, wbyte};
            done     = ({1'b0, k_q} == (size - 3'd1));
          end
        end else if (crossing && (k_q == 2'd0)) begin
          addr_out   = addr_q;
          lo_capture = 1'b1;
        end else if (crossing) begin
          addr_out = {addr_q[31:2], 2'b00} + 32'd4;
          done     = 1'b1;
        end else begin
          addr_out = addr_q;
          done     = 1'b1;
        end
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Request latch, access counter and low-word capture for crossing loads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      k_q     <= '0;
    end else if (state_q == IDLE) begin
      if (bus.req_valid) begin
        store_q <= bus.req_store;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        k_q     <= '0;
      end
    end else begin
      k_q <= k_q + 2'd1;
      if (lo_capture) lo_q <= bus.mem_rd;
    end
  end

  // Registered one-cycle response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= done;
      rsp_rdata_q <= (done && !store_q && !illegal) ? lext : '0;
      rsp_err_q   <= done && illegal;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.mem_we    = we;
  assign bus.mem_a     = addr_out;
  assign bus.mem_wd    = wd_out;

endmodule

// File: tb/tb_lsu_align.sv
// Testbench for lsu_align: word-addressed memory model behind the unit,
// directed vector table plus hand-written multi-cycle sequences.
module tb_lsu_align;

  typedef struct {
    logic        store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        pre;
    logic [31:0] m0;
    logic [31:0] m1;
    logic [31:0] expRdata;
    logic        expErr;
    int          expLat;
    int          expWe;
    logic [31:0] expM0;
    logic [31:0] expM1;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  lsu_if #(.XLEN(32)) bus ();

  logic [31:0] mem [0:255];
  logic        preEn;
  logic [7:0]  preIdx;
  logic [31:0] preData;

  int nCompared = 0;
  int nMismatched = 0;
  vec_t vecs[$];

  int          gotLat, gotWe;
  logic [31:0] gotRdata;
  logic        gotErr;
  logic        gotPulse;

  lsu_align #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rd = mem[bus.mem_a[9:2]];

  // Memory model: preload port or the unit's write-enable encoding
  always @(posedge clk) begin
    if (preEn) begin
      mem[preIdx] <= preData;
    end else begin
      case (bus.mem_we)
        2'b01: mem[bus.mem_a[9:2]] <= bus.mem_wd;
        2'b10: begin
          if (bus.mem_a[1]) mem[bus.mem_a[9:2]][31:16] <= bus.mem_wd[15:0];
          else              mem[bus.mem_a[9:2]][15:0]  <= bus.mem_wd[15:0];
        end
        2'b11: begin
          case (bus.mem_a[1:0])
            2'b00: mem[bus.mem_a[9:2]][7:0]   <= bus.mem_wd[7:0];
            2'b01: mem[bus.mem_a[9:2]][15:8]  <= bus.mem_wd[7:0];
            2'b10: mem[bus.mem_a[9:2]][23:16] <= bus.mem_wd[7:0];
            default: mem[bus.mem_a[9:2]][31:24] <= bus.mem_wd[7:0];
          endcase
        end
        default: ;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic preloadWord(input logic [7:0] idx, input logic [31:0] data);
    @(negedge clk);
    preEn = 1'b1; preIdx = idx; preData = data;
    @(posedge clk);
    #1 preEn = 1'b0;
  endtask

  task automatic issue(input logic store, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_store = store; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wdata;
    @(posedge clk);
  endtask

  task automatic addVec(input logic store, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic pre, input logic [31:0] m0,
                        input logic [31:0] m1, input logic [31:0] expRdata, input logic expErr,
                        input int expLat, input int expWe, input logic [31:0] expM0,
                        input logic [31:0] expM1, input string name);
    vec_t v;
    v.store = store; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.pre = pre;
    v.m0 = m0; v.m1 = m1; v.expRdata = expRdata; v.expErr = expErr;
    v.expLat = expLat; v.expWe = expWe; v.expM0 = expM0; v.expM1 = expM1; v.name = name;
    vecs.push_back(v);
  endtask

  // Runs one request and waits (bounded) for its response
  task automatic applyStimulus(input vec_t v);
    if (v.pre) begin
      preloadWord(8'h40, v.m0);
      preloadWord(8'h41, v.m1);
    end
    issue(v.store, v.f3, v.addr, v.wdata);
    gotLat = 0; gotWe = 0; gotRdata = 'x; gotErr = 1'bx; gotPulse = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_valid = 1'b0;
      if (bus.mem_we != 2'b00) gotWe++;
      if (bus.rsp_valid) begin
        gotLat = c; gotRdata = bus.rsp_rdata; gotErr = bus.rsp_err;
        break;
      end
    end
    @(negedge clk);
    gotPulse = bus.rsp_valid;
  endtask

  initial begin
    int          weIdx;
    logic [31:0] seenA [0:3];
    logic [31:0] seenWd [0:3];
    logic [31:0] expByte;
    int          extraRsp;
    logic [31:0] wrapA;

    rst_n = 1'b0;
    preEn = 1'b0; preIdx = '0; preData = '0;
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0;

    addVec(1, 3'b010, 32'h100, 32'hDEADBEEF, 1, 32'h0, 32'h0, 32'h0, 0, 2, 1, 32'hDEADBEEF, 32'h0, "sw_word");
    addVec(0, 3'b010, 32'h100, 32'h0, 0, 32'h0, 32'h0, 32'hDEADBEEF, 0, 2, 0, 32'hDEADBEEF, 32'h0, "lw_word");
    addVec(0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF1234, 32'h0, 32'hFFFFFF80, 0, 2, 0, 32'h80FF1234, 32'h0, "lb_neg");
    addVec(0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF1234, 32'h0, 32'h00000080, 0, 2, 0, 32'h80FF1234, 32'h0, "lbu");
    addVec(0, 3'b001, 32'h102, 32'h0, 1, 32'h80FF1234, 32'h0, 32'hFFFF80FF, 0, 2, 0, 32'h80FF1234, 32'h0, "lh_neg");
    addVec(0, 3'b101, 32'h100, 32'h0, 1, 32'h80FF1234, 32'h0, 32'h00001234, 0, 2, 0, 32'h80FF1234, 32'h0, "lhu");
    addVec(0, 3'b010, 32'h102, 32'h0, 1, 32'h44332211, 32'h88776655, 32'h66554433, 0, 3, 0, 32'h44332211, 32'h88776655, "lw_cross");
    addVec(0, 3'b001, 32'h103, 32'h0, 1, 32'h44332211, 32'h88776655, 32'h00005544, 0, 3, 0, 32'h44332211, 32'h88776655, "lh_cross");
    addVec(0, 3'b001, 32'h103, 32'h0, 1, 32'h44332211, 32'h887766F5, 32'hFFFFF544, 0, 3, 0, 32'h44332211, 32'h887766F5, "lh_cross_neg");
    addVec(0, 3'b101, 32'h103, 32'h0, 1, 32'h44332211, 32'h887766F5, 32'h0000F544, 0, 3, 0, 32'h44332211, 32'h887766F5, "lhu_cross");
    addVec(0, 3'b001, 32'h101, 32'h0, 1, 32'h44332211, 32'h88776655, 32'h00003322, 0, 2, 0, 32'h44332211, 32'h88776655, "lh_mis_in_word");
    addVec(1, 3'b010, 32'h101, 32'hA1B2C3D4, 1, 32'h44332211, 32'h88776655, 32'h0, 0, 5, 4, 32'hB2C3D411, 32'h887766A1, "sw_mis");
    addVec(1, 3'b001, 32'h102, 32'hFFFFBEEF, 1, 32'h44332211, 32'h88776655, 32'h0, 0, 2, 1, 32'hBEEF2211, 32'h88776655, "sh_aligned");
    addVec(1, 3'b000, 32'h101, 32'h123456AB, 1, 32'h44332211, 32'h88776655, 32'h0, 0, 2, 1, 32'h4433AB11, 32'h88776655, "sb");
    addVec(1, 3'b001, 32'h101, 32'h00001234, 1, 32'h44332211, 32'h88776655, 32'h0, 0, 3, 2, 32'h44123411, 32'h88776655, "sh_mis_in_word");
    addVec(1, 3'b001, 32'h103, 32'h00001234, 1, 32'h44332211, 32'h88776655, 32'h0, 0, 3, 2, 32'h34332211, 32'h88776612, "sh_cross");
    addVec(0, 3'b011, 32'h100, 32'h0, 1, 32'h44332211, 32'h88776655, 32'h0, 1, 2, 0, 32'h44332211, 32'h88776655, "ill_load_011");
    addVec(0, 3'b110, 32'h100, 32'h0, 1, 32'h44332211, 32'h88776655, 32'h0, 1, 2, 0, 32'h44332211, 32'h88776655, "ill_load_110");
    addVec(1, 3'b100, 32'h100, 32'hFFFFFFFF, 1, 32'h44332211, 32'h88776655, 32'h0, 1, 2, 0, 32'h44332211, 32'h88776655, "ill_store_100");

    // Reset values
    #1;
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    checkOutput("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    checkOutput("rst_mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("rst_mem_a", bus.mem_a, 32'h0);
    checkOutput("rst_mem_wd", bus.mem_wd, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput({vecs[i].name, "_latency"}, 32'(gotLat), 32'(vecs[i].expLat));
      checkOutput({vecs[i].name, "_rdata"}, gotRdata, vecs[i].expRdata);
      checkOutput({vecs[i].name, "_err"}, 32'(gotErr), 32'(vecs[i].expErr));
      checkOutput({vecs[i].name, "_we_cycles"}, 32'(gotWe), 32'(vecs[i].expWe));
      checkOutput({vecs[i].name, "_pulse_len"}, 32'(gotPulse), 32'd0);
      checkOutput({vecs[i].name, "_mem100"}, mem[8'h40], vecs[i].expM0);
      checkOutput({vecs[i].name, "_mem104"}, mem[8'h41], vecs[i].expM1);
    end

    // Misaligned SW: byte addresses ascend and each carries the next data byte
    preloadWord(8'h40, 32'h44332211);
    preloadWord(8'h41, 32'h88776655);
    issue(1'b1, 3'b010, 32'h101, 32'hA1B2C3D4);
    weIdx = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_valid = 1'b0;
      if (bus.mem_we == 2'b11 && weIdx < 4) begin
        seenA[weIdx] = bus.mem_a; seenWd[weIdx] = bus.mem_wd; weIdx++;
      end
      if (bus.rsp_valid) break;
    end
    checkOutput("swmis_byte_count", 32'(weIdx), 32'd4);
    for (int i = 0; i < 4; i++) begin
      expByte = 32'hA1B2C3D4 >> (8 * i);
      checkOutput($sformatf("swmis_addr%0d", i), seenA[i], 32'h101 + 32'(i));
      checkOutput($sformatf("swmis_wd%0d", i), seenWd[i], {24'b0, expByte[7:0]});
    end

    // Crossing load at the top of the address space wraps to address 0
    preloadWord(8'hFF, 32'h44332211);
    preloadWord(8'h00, 32'h88776655);
    issue(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);
    gotLat = 0; wrapA = 32'hFFFFFFFF; gotRdata = 'x;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_valid = 1'b0;
      if (c == 2) wrapA = bus.mem_a;
      if (bus.rsp_valid) begin
        gotLat = c; gotRdata = bus.rsp_rdata;
        break;
      end
    end
    checkOutput("wrap_second_addr", wrapA, 32'h0);
    checkOutput("wrap_latency", 32'(gotLat), 32'd3);
    checkOutput("wrap_rdata", gotRdata, 32'h66554433);

    // Reset during the third byte of a misaligned SW
    preloadWord(8'h40, 32'h44332211);
    preloadWord(8'h41, 32'h88776655);
    issue(1'b1, 3'b010, 32'h101, 32'hA1B2C3D4);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("midrst_third_byte_addr", bus.mem_a, 32'h103);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_we_drop", 32'(bus.mem_we), 32'd0);
    checkOutput("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    extraRsp = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) extraRsp++;
    end
    checkOutput("midrst_no_rsp", 32'(extraRsp), 32'd0);
    checkOutput("midrst_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("midrst_mem100", mem[8'h40], 32'h44C3D411);
    checkOutput("midrst_mem104", mem[8'h41], 32'h88776655);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
